// File: rtl/pdm_pkg.sv
// Shared types and constants for the multi-channel PDM modulator.
package pdm_pkg;

  typedef enum logic {
    PDM_ORD1 = 1'b0,
    PDM_ORD2 = 1'b1
  } pdm_mode_e;

  // Extra integrator bits above WIDTH so second-order loops have headroom before saturating.
  localparam int unsigned PDM_GUARD = 4;

endpackage

// File: rtl/pdm_multi_if.sv
// Host-side bundle for pdm_multi: shadow write / commit / divider controls and the PDM outputs.
interface pdm_multi_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 8,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                wr_en;
  logic [CW-1:0]       wr_chan;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_mode;
  logic                commit;
  logic [DIV_W-1:0]    div;
  logic [CHANNELS-1:0] pdm_out;
  logic                tick;
  logic                commit_pending;

  modport master (
    output wr_en, wr_chan, wr_data, wr_mode, commit, div,
    input  pdm_out, tick, commit_pending
  );

  modport slave (
    input  wr_en, wr_chan, wr_data, wr_mode, commit, div,
    output pdm_out, tick, commit_pending
  );
endinterface

// File: rtl/pdm_chan.sv
// One PDM channel: first-order accumulator or saturating second-order sigma-delta loop.
module pdm_chan
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             clear,
  input  logic [WIDTH-1:0] x,
  input  pdm_mode_e        mode,
  output logic             pdm
);

  localparam int unsigned IW = WIDTH + PDM_GUARD;
  localparam int unsigned EW = IW + 2;
  localparam logic signed [EW-1:0] SAT_MAX = {{3{1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{3{1'b1}}, {(IW-1){1'b0}}};

  logic        [WIDTH-1:0] acc;
  logic signed [IW-1:0]    i1, i2, i1_nx, i2_nx;
  logic        [WIDTH:0]   sum1;
  logic signed [EW-1:0]    fb, xs, i1_raw, i2_raw;

  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[IW-1:0];
    if (v < SAT_MIN) return SAT_MIN[IW-1:0];
    return v[IW-1:0];
  endfunction

  // Next-state arithmetic for both orders; mode selects which one is committed on tick.
  always_comb begin
    sum1 = {1'b0, acc} + {1'b0, x};
    fb   = '0;
    if (pdm) fb[WIDTH] = 1'b1;
    xs     = $signed({{(EW-WIDTH){1'b0}}, x});
    i1_raw = EW'(i1) + xs - fb;
    i1_nx  = sat(i1_raw);
    i2_raw = EW'(i2) + EW'(i1_nx) - fb;
    i2_nx  = sat(i2_raw);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      i1  <= '0;
      i2  <= '0;
      pdm <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      i1  <= '0;
      i2  <= '0;
      pdm <= 1'b0;
    end else if (tick) begin
      if (mode == PDM_ORD1) begin
        acc <= sum1[WIDTH-1:0];
        pdm <= sum1[WIDTH];
      end else begin
        i1  <= i1_nx;
        i2  <= i2_nx;
        pdm <= !i2_nx[IW-1] && (i2_nx != '0);
      end
    end
  end

endmodule

// File: rtl/pdm_multi.sv
// Multi-channel PDM generator: shared tick divider, shadow/active register banks with tick-aligned commit.
module pdm_multi
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 8,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_mode,
  input  logic                commit,
  input  logic [DIV_W-1:0]    div,
  output logic [CHANNELS-1:0] pdm_out,
  output logic                tick,
  output logic                commit_pending
);

  logic [DIV_W-1:0]                cnt;
  logic [CHANNELS-1:0][WIDTH-1:0]  sh_data, sh_data_nx, act_data;
  logic [CHANNELS-1:0]             sh_mode, sh_mode_nx, act_mode, clr;
  logic                            apply;

  // Live compare against div so a reprogrammed period takes effect immediately.
  assign tick  = reset_n & (cnt == div);
  assign apply = tick & (commit_pending | commit);
  assign clr   = {CHANNELS{apply}} & (act_mode ^ sh_mode_nx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (cnt >= div) cnt <= '0;
    else                 cnt <= cnt + DIV_W'(1);
  end

  // Same-cycle write is visible to a same-cycle commit through the _nx view.
  always_comb begin
    sh_data_nx = sh_data;
    sh_mode_nx = sh_mode;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (wr_en && (wr_chan == CW'(c))) begin
        sh_data_nx[c] = wr_data;
        sh_mode_nx[c] = wr_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_data        <= '0;
      sh_mode        <= '0;
      act_data       <= '0;
      act_mode       <= '0;
      commit_pending <= 1'b0;
    end else begin
      sh_data <= sh_data_nx;
      sh_mode <= sh_mode_nx;
      if (apply) begin
        act_data <= sh_data_nx;
        act_mode <= sh_mode_nx;
      end
      commit_pending <= apply ? 1'b0 : (commit_pending | commit);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pdm_chan #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .clear   (clr[c]),
      .x       (act_data[c]),
      .mode    (pdm_mode_e'(act_mode[c])),
      .pdm     (pdm_out[c])
    );
  end

endmodule

// File: tb/tb_pdm_multi.sv
// Bench for pdm_multi: 4-channel and 3-channel instances on shared stimulus, checked against a behavioural model.
module tb_pdm_multi;
  import pdm_pkg::*;

  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int IMAX = (1 << (W + PDM_GUARD - 1)) - 1;
  localparam int IMIN = -(1 << (W + PDM_GUARD - 1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pdm_multi_if #(.WIDTH(W), .CHANNELS(4), .DIV_W(8)) bus_a ();
  pdm_multi_if #(.WIDTH(W), .CHANNELS(3), .DIV_W(8)) bus_b ();

  assign bus_b.wr_en   = bus_a.wr_en;
  assign bus_b.wr_chan = bus_a.wr_chan;
  assign bus_b.wr_data = bus_a.wr_data;
  assign bus_b.wr_mode = bus_a.wr_mode;
  assign bus_b.commit  = bus_a.commit;
  assign bus_b.div     = bus_a.div;

  pdm_multi #(.WIDTH(W), .CHANNELS(4), .DIV_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(bus_a.wr_en), .wr_chan(bus_a.wr_chan),
    .wr_data(bus_a.wr_data), .wr_mode(bus_a.wr_mode), .commit(bus_a.commit), .div(bus_a.div),
    .pdm_out(bus_a.pdm_out), .tick(bus_a.tick), .commit_pending(bus_a.commit_pending));

  pdm_multi #(.WIDTH(W), .CHANNELS(3), .DIV_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(bus_b.wr_en), .wr_chan(bus_b.wr_chan),
    .wr_data(bus_b.wr_data), .wr_mode(bus_b.wr_mode), .commit(bus_b.commit), .div(bus_b.div),
    .pdm_out(bus_b.pdm_out), .tick(bus_b.tick), .commit_pending(bus_b.commit_pending));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: index [instance][channel]; instance 0 has 4 channels, instance 1 has 3.
  int nch [2] = '{4, 3};
  int m_cnt;
  bit m_pend;
  int sd [2][4]; bit sm [2][4];
  int ad [2][4]; bit am [2][4];
  int acc[2][4]; int i1[2][4]; int i2[2][4]; bit mo[2][4];

  function automatic int clamp(int v);
    if (v > IMAX) return IMAX;
    if (v < IMIN) return IMIN;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pend = 0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin
        sd[i][c] = 0; sm[i][c] = 0; ad[i][c] = 0; am[i][c] = 0;
        acc[i][c] = 0; i1[i][c] = 0; i2[i][c] = 0; mo[i][c] = 0;
      end
  endtask

  task automatic model_step();
    int dv;
    bit tk, ap;
    int s, f, n1, n2;
    dv = int'(bus_a.div);
    tk = (m_cnt == dv);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < nch[i]; c++)
        if (bus_a.wr_en && int'(bus_a.wr_chan) == c) begin
          sd[i][c] = int'(bus_a.wr_data);
          sm[i][c] = bus_a.wr_mode;
        end
    ap = tk && (m_pend || bus_a.commit);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < nch[i]; c++) begin
        if (ap && (sm[i][c] != am[i][c])) begin
          acc[i][c] = 0; i1[i][c] = 0; i2[i][c] = 0; mo[i][c] = 0;
        end else if (tk) begin
          if (!am[i][c]) begin
            s = acc[i][c] + ad[i][c];
            mo[i][c]  = (s >= FULL);
            acc[i][c] = s % FULL;
          end else begin
            f  = mo[i][c] ? FULL : 0;
            n1 = clamp(i1[i][c] + ad[i][c] - f);
            n2 = clamp(i2[i][c] + n1 - f);
            i1[i][c] = n1; i2[i][c] = n2;
            mo[i][c] = (n2 > 0);
          end
        end
        if (ap) begin
          ad[i][c] = sd[i][c];
          am[i][c] = sm[i][c];
        end
      end
    m_pend = ap ? 1'b0 : (m_pend || bus_a.commit);
    m_cnt  = (m_cnt >= dv) ? 0 : m_cnt + 1;
  endtask

  function automatic int exp_pdm(int i);
    int v = 0;
    for (int c = 0; c < nch[i]; c++) if (mo[i][c]) v += (1 << c);
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("tick_a", bus_a.tick, (reset_n && m_cnt == int'(bus_a.div)));
      chk("tick_b", bus_b.tick, (reset_n && m_cnt == int'(bus_a.div)));
      chk("pend_a", bus_a.commit_pending, m_pend);
      chk("pdm_a", bus_a.pdm_out, exp_pdm(0));
      chk("pdm_b", bus_b.pdm_out, exp_pdm(1));
    end
  end

  task automatic wr(input int ch, input int d, input bit m, input bit cm);
    bus_a.wr_en = 1'b1; bus_a.wr_chan = 2'(ch); bus_a.wr_data = 8'(d);
    bus_a.wr_mode = m; bus_a.commit = cm;
  endtask

  task automatic idle();
    bus_a.wr_en = 1'b0; bus_a.commit = 1'b0;
  endtask

  task automatic wait_tick(input string nm);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus_a.tick) return;
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int ones0, ones1, ones2, ones3, first0, ntick, npend;
    bit found;
    bus_a.wr_en = 0; bus_a.wr_chan = 0; bus_a.wr_data = 0; bus_a.wr_mode = 0;
    bus_a.commit = 0; bus_a.div = 0;

    // Reset state, with div=0 so the divider would otherwise be ticking.
    repeat (2) @(negedge clk);
    chk("rst_tick", bus_a.tick, 0);
    chk("rst_pend", bus_a.commit_pending, 0);
    chk("rst_pdm", bus_a.pdm_out, 0);
    #1 reset_n = 1'b1;

    // Load all four channels; last write carries the commit.
    @(negedge clk); #1 wr(0, 64, 0, 0);
    @(negedge clk); #1 wr(1, 255, 0, 0);
    @(negedge clk); #1 wr(2, 0, 0, 0);
    @(negedge clk); #1 wr(3, 128, 1, 1);
    @(negedge clk); #1 idle();
    ones0 = 0; ones1 = 0; ones2 = 0; ones3 = 0; first0 = 0;
    for (int k = 1; k <= 1024; k++) begin
      @(negedge clk);
      if (k <= 256) begin
        ones0 += int'(bus_a.pdm_out[0]);
        ones1 += int'(bus_a.pdm_out[1]);
        ones2 += int'(bus_a.pdm_out[2]);
      end
      ones3 += int'(bus_a.pdm_out[3]);
      if (first0 == 0 && bus_a.pdm_out[0]) first0 = k;
    end
    chk("ch0_first_one", first0, 4);
    chk("ch0_density", ones0, 64);
    chk("ch1_density", ones1, 255);
    chk("ch2_density", ones2, 0);
    chk("ch3_ord2_near", ((ones3 >= 510) && (ones3 <= 514)), 1);

    // Mode change ORD2 -> ORD1 while the bit is high: apply edge clears it.
    found = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      found = bus_a.pdm_out[3];
    end
    chk("ch3_found_one", found, 1);
    #1 wr(3, 128, 0, 1);
    @(negedge clk);
    chk("ch3_cleared", bus_a.pdm_out[3], 0);
    #1 idle();

    // div=3: one tick every fourth cycle.
    @(negedge clk); #1 bus_a.div = 8'd3;
    ntick = 0;
    repeat (40) begin @(negedge clk); ntick += int'(bus_a.tick); end
    chk("div3_ticks", ntick, 10);

    // Commit one cycle after a tick stays pending for three cycles.
    wait_tick("pend_setup");
    @(negedge clk); #1 bus_a.commit = 1'b1;
    @(negedge clk); npend = int'(bus_a.commit_pending); #1 bus_a.commit = 1'b0;
    repeat (5) begin @(negedge clk); npend += int'(bus_a.commit_pending); end
    chk("pend_len", npend, 3);

    // Out-of-range channel for the 3-channel instance, write+commit together.
    @(negedge clk); #1 wr(3, 200, 1, 1);
    @(negedge clk); #1 idle();
    repeat (12) @(negedge clk);
    chk("pend_cleared", bus_a.commit_pending, 0);

    // Randomized traffic including live div changes.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      bus_a.wr_en   = ($urandom_range(0, 2) == 0);
      bus_a.wr_chan = 2'($urandom_range(0, 3));
      bus_a.wr_data = 8'($urandom);
      bus_a.wr_mode = 1'($urandom);
      bus_a.commit  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) bus_a.div = 8'($urandom_range(0, 5));
    end
    @(negedge clk); #1 idle();

    // Reset mid-stream with a commit pending.
    bus_a.div = 8'd7;
    wait_tick("rst_setup");
    @(negedge clk); #1 wr(1, 255, 0, 1);
    @(negedge clk); #1 idle();
    @(negedge clk);
    chk("pend_before_rst", bus_a.commit_pending, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_pend", bus_a.commit_pending, 0);
    chk("midrst_pdm_a", bus_a.pdm_out, 0);
    chk("midrst_pdm_b", bus_b.pdm_out, 0);
    chk("midrst_tick", bus_a.tick, 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_pdm_a", bus_a.pdm_out, 0);
    chk("post_rst_pdm_b", bus_b.pdm_out, 0);
    chk("post_rst_pend", bus_a.commit_pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
